// File: rtl/i2c_cfg_pkg.sv
// Shared types and the default WM8731 power-up register table for the
// codec configuration master.
package i2c_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BYTE,
    ST_ACK,
    ST_STOP,
    ST_GAP,
    ST_DONE,
    ST_ERR
  } cfg_state_t;

  typedef logic [1:0] qphase_t;

  localparam qphase_t Q0 = 2'd0;
  localparam qphase_t Q1 = 2'd1;
  localparam qphase_t Q2 = 2'd2;
  localparam qphase_t Q3 = 2'd3;

  // WM8731 control register addresses (upper 7 bits of each 16-bit word)
  localparam logic [6:0] WM_LLIN   = 7'h00;
  localparam logic [6:0] WM_RLIN   = 7'h01;
  localparam logic [6:0] WM_LHP    = 7'h02;
  localparam logic [6:0] WM_RHP    = 7'h03;
  localparam logic [6:0] WM_APATH  = 7'h04;
  localparam logic [6:0] WM_DPATH  = 7'h05;
  localparam logic [6:0] WM_PWR    = 7'h06;
  localparam logic [6:0] WM_IFACE  = 7'h07;
  localparam logic [6:0] WM_SRATE  = 7'h08;
  localparam logic [6:0] WM_ACTIVE = 7'h09;
  localparam logic [6:0] WM_RESET  = 7'h0F;

  function automatic logic [15:0] wm_word(input logic [6:0] addr, input logic [8:0] data);
    return {addr, data};
  endfunction

  localparam int DEFAULT_NUM_REGS = 8;

  // Entry 0 sits in the low 16 bits and is sent first.
  localparam logic [DEFAULT_NUM_REGS*16-1:0] DEFAULT_TABLE = {
    wm_word(WM_ACTIVE, 9'h001),
    wm_word(WM_IFACE,  9'h00A),
    wm_word(WM_DPATH,  9'h000),
    wm_word(WM_APATH,  9'h012),
    wm_word(WM_RHP,    9'h179),
    wm_word(WM_LHP,    9'h179),
    wm_word(WM_PWR,    9'h002),
    wm_word(WM_RESET,  9'h000)
  };

endpackage

// File: rtl/i2c_codec_cfg_master_tick.sv
// Quarter-SCL-period timebase: one-cycle qtick every CLK_DIV clocks and a
// 2-bit phase that advances on each qtick. Held at zero while disabled.
module i2c_tick_gen
  import i2c_cfg_pkg::*;
#(
  parameter int CLK_DIV = 125
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    en,
  output logic    qtick,
  output qphase_t phase
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign qtick = en && (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      phase <= Q0;
    end else if (!en) begin
      cnt   <= '0;
      phase <= Q0;
    end else if (qtick) begin
      cnt   <= '0;
      phase <= phase + 2'd1;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_codec_cfg_master.sv
// Table-driven I2C write master that programs an audio codec after reset or
// on request, retrying NACKed entries and flagging the first entry that fails.
module i2c_codec_cfg_master
  import i2c_cfg_pkg::*;
#(
  parameter int                     CLK_DIV    = 125,
  parameter logic [6:0]             DEV_ADDR   = 7'h1A,
  parameter int                     NUM_REGS   = DEFAULT_NUM_REGS,
  parameter logic [NUM_REGS*16-1:0] INIT_TABLE = DEFAULT_TABLE,
  parameter int                     MAX_RETRY  = 3,
  parameter int                     AUTO_START = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_in,
  output logic       busy,
  output logic       config_done,
  output logic       config_err,
  output logic [7:0] err_index
);

  localparam logic [7:0] ADDR_BYTE  = {DEV_ADDR, 1'b0};
  localparam logic [7:0] LAST_ENTRY = 8'(NUM_REGS - 1);
  localparam logic [3:0] RETRY_MAX  = 4'(MAX_RETRY);

  cfg_state_t  state, state_nxt;
  qphase_t     phase;
  logic        qtick;
  logic        tick_en;
  logic        bit_end;
  logic        go;
  logic        auto_pend;
  logic [7:0]  shift;
  logic [2:0]  bit_cnt;
  logic [1:0]  byte_idx;
  logic [7:0]  entry;
  logic [3:0]  retry;
  logic        nack;
  logic        ack_bit;
  logic [15:0] cur_word;
  logic        scl_d, sda_d, sda_dly;

  assign tick_en = (state == ST_START) || (state == ST_BYTE) || (state == ST_ACK) ||
                   (state == ST_STOP)  || (state == ST_GAP);
  assign busy    = tick_en;
  assign bit_end = qtick && (phase == Q3);
  assign go      = start || auto_pend;

  i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (tick_en),
    .qtick (qtick),
    .phase (phase)
  );

  always_comb begin
    cur_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (entry == 8'(i)) cur_word = INIT_TABLE[16*i +: 16];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    scl_d     = 1'b0;
    sda_d     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (go) state_nxt = ST_START;
      end
      ST_START: begin
        scl_d = (phase == Q3);
        sda_d = (phase == Q2) || (phase == Q3);
        if (bit_end) state_nxt = ST_BYTE;
      end
      ST_BYTE: begin
        scl_d = (phase == Q0) || (phase == Q1);
        sda_d = ~shift[7];
        if (bit_end && (bit_cnt == 3'd7)) state_nxt = ST_ACK;
      end
      ST_ACK: begin
        scl_d = (phase == Q0) || (phase == Q1);
        if (bit_end) begin
          if (ack_bit || (byte_idx == 2'd2)) state_nxt = ST_STOP;
          else                               state_nxt = ST_BYTE;
        end
      end
      ST_STOP: begin
        scl_d = (phase == Q0) || (phase == Q1);
        sda_d = (phase != Q3);
        if (bit_end) state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (bit_end) begin
          if (nack)                      state_nxt = (retry >= RETRY_MAX) ? ST_ERR : ST_START;
          else if (entry == LAST_ENTRY)  state_nxt = ST_DONE;
          else                           state_nxt = ST_START;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      ST_ERR:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      auto_pend   <= (AUTO_START != 0);
      shift       <= '0;
      bit_cnt     <= '0;
      byte_idx    <= '0;
      entry       <= '0;
      retry       <= '0;
      nack        <= 1'b0;
      ack_bit     <= 1'b0;
      config_done <= 1'b0;
      config_err  <= 1'b0;
      err_index   <= '0;
    end else begin
      if ((state == ST_IDLE) && go) begin
        auto_pend   <= 1'b0;
        entry       <= '0;
        retry       <= '0;
        nack        <= 1'b0;
        config_done <= 1'b0;
        config_err  <= 1'b0;
        err_index   <= '0;
      end
      if (qtick && (phase == Q2) && (state == ST_ACK)) ack_bit <= sda_in;
      if (bit_end) begin
        case (state)
          ST_START: begin
            shift    <= ADDR_BYTE;
            bit_cnt  <= '0;
            byte_idx <= '0;
            nack     <= 1'b0;
          end
          ST_BYTE: begin
            if (bit_cnt != 3'd7) begin
              bit_cnt <= bit_cnt + 3'd1;
              shift   <= {shift[6:0], 1'b0};
            end
          end
          ST_ACK: begin
            if (ack_bit) begin
              nack <= 1'b1;
            end else if (byte_idx != 2'd2) begin
              byte_idx <= byte_idx + 2'd1;
              bit_cnt  <= '0;
              shift    <= (byte_idx == 2'd0) ? cur_word[15:8] : cur_word[7:0];
            end
          end
          ST_GAP: begin
            if (nack) begin
              if (retry >= RETRY_MAX) begin
                config_err <= 1'b1;
                err_index  <= entry;
              end else begin
                retry <= retry + 4'd1;
              end
            end else if (entry == LAST_ENTRY) begin
              config_done <= 1'b1;
            end else begin
              entry <= entry + 8'd1;
              retry <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // SDA trails SCL by one extra clock so data never moves on an SCL edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_oe  <= 1'b0;
      sda_dly <= 1'b0;
      sda_oe  <= 1'b0;
    end else begin
      scl_oe  <= scl_d;
      sda_dly <= sda_d;
      sda_oe  <= sda_dly;
    end
  end

endmodule

// File: tb/tb_i2c_codec_cfg_master.sv
// Directed bench: one ACKing slave model on an auto-starting instance and a
// silent bus on a manually started instance.
module tb_i2c_codec_cfg_master;

  logic       clk = 1'b0;
  logic       reset, rst_b;
  logic       start, start_b;
  logic       scl_oe, sda_oe, sda_in, busy, config_done, config_err;
  logic [7:0] err_index;
  logic       scl_oe_b, sda_oe_b, sda_in_b, busy_b, config_done_b, config_err_b;
  logic [7:0] err_index_b;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  i2c_codec_cfg_master #(
    .CLK_DIV(4), .DEV_ADDR(7'h1A), .NUM_REGS(2), .INIT_TABLE(32'h0C00_1E00),
    .MAX_RETRY(2), .AUTO_START(1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .sda_in(sda_in), .busy(busy), .config_done(config_done),
    .config_err(config_err), .err_index(err_index)
  );

  i2c_codec_cfg_master #(
    .CLK_DIV(4), .DEV_ADDR(7'h1A), .NUM_REGS(2), .INIT_TABLE(32'h0C00_1E00),
    .MAX_RETRY(2), .AUTO_START(0)
  ) dut_b (
    .clk(clk), .reset(rst_b), .start(start_b), .scl_oe(scl_oe_b), .sda_oe(sda_oe_b),
    .sda_in(sda_in_b), .busy(busy_b), .config_done(config_done_b),
    .config_err(config_err_b), .err_index(err_index_b)
  );

  // Bus monitor and slave model for dut
  int         nack_mode;
  logic       mon_clr;
  logic       slave_low;
  logic       p_scl, p_sda;
  int         starts, stops, nacks, sim_chg, tim_err, hi_chk, lo_chk;
  int         rise_idx, bitn, nbyte, run_len;
  logic [7:0] sr;
  logic [7:0] byte_q[$];

  assign sda_in   = ~sda_oe & ~slave_low;
  assign sda_in_b = ~sda_oe_b;

  always @(negedge clk) begin
    if (reset || mon_clr) begin
      starts <= 0; stops <= 0; nacks <= 0; sim_chg <= 0; tim_err <= 0;
      hi_chk <= 0; lo_chk <= 0; rise_idx <= 0; bitn <= 0; nbyte <= 0;
      run_len <= 0; sr <= 8'h00; slave_low <= 1'b0;
      byte_q.delete();
    end else begin
      run_len <= (scl_oe != p_scl) ? 1 : run_len + 1;
      if ((scl_oe != p_scl) && (sda_oe != p_sda)) sim_chg <= sim_chg + 1;
      if (!scl_oe && !p_scl && sda_oe && !p_sda) begin
        starts <= starts + 1; rise_idx <= 0; bitn <= 0; nbyte <= 0;
      end
      if (!scl_oe && !p_scl && !sda_oe && p_sda) stops <= stops + 1;
      if (!scl_oe && p_scl) begin
        rise_idx <= rise_idx + 1;
        if (rise_idx > 0) begin
          lo_chk <= lo_chk + 1;
          if (run_len != 8) tim_err <= tim_err + 1;
        end
        if (bitn < 8) begin
          sr   <= {sr[6:0], ~sda_oe};
          bitn <= bitn + 1;
          if (bitn == 7) begin
            byte_q.push_back({sr[6:0], ~sda_oe});
            nbyte <= nbyte + 1;
          end
        end else begin
          bitn <= 0;
          if (sda_in) nacks <= nacks + 1;
        end
      end
      if (scl_oe && !p_scl) begin
        if (rise_idx > 0) begin
          hi_chk <= hi_chk + 1;
          if (run_len != 8) tim_err <= tim_err + 1;
        end
        slave_low <= (bitn == 8) && !((nack_mode == 1) && (starts == 2) && (nbyte == 2));
      end
    end
    p_scl <= scl_oe;
    p_sda <= sda_oe;
  end

  int   starts_b;
  logic p_scl_b, p_sda_b;

  always @(negedge clk) begin
    if (rst_b) starts_b <= 0;
    else if (!scl_oe_b && !p_scl_b && sda_oe_b && !p_sda_b) starts_b <= starts_b + 1;
    p_scl_b <= scl_oe_b;
    p_sda_b <= sda_oe_b;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 4000 && !config_done; i++) tick(1);
    chk(tag, config_done, 1'b1);
  endtask

  task automatic chk_bytes(input string tag, input logic [7:0] exp[$]);
    logic [31:0] obs;
    chk({tag, "_count"}, byte_q.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      obs = (i < byte_q.size()) ? {24'h0, byte_q[i]} : 32'hDEAD;
      chk($sformatf("%s_byte%0d", tag, i), obs, {24'h0, exp[i]});
    end
  endtask

  logic [7:0] exp_full[$];
  logic [7:0] exp_nack[$];

  initial begin
    exp_full = '{8'h34, 8'h1E, 8'h00, 8'h34, 8'h0C, 8'h00};
    exp_nack = '{8'h34, 8'h1E, 8'h00, 8'h34, 8'h0C, 8'h34, 8'h0C, 8'h00};
    reset = 1'b1; rst_b = 1'b1; start = 1'b0; start_b = 1'b0;
    nack_mode = 0; mon_clr = 1'b0;
    tick(3);

    chk("rst_scl_oe", scl_oe, 1'b0);
    chk("rst_sda_oe", sda_oe, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", config_done, 1'b0);
    chk("rst_err", config_err, 1'b0);
    chk("rst_err_index", err_index, 8'h00);

    // Manual-start instance stays idle, then exhausts retries on a silent bus
    rst_b = 1'b0;
    tick(200);
    chk("t4_idle_busy", busy_b, 1'b0);
    chk("t4_idle_scl", scl_oe_b, 1'b0);
    chk("t4_idle_sda", sda_oe_b, 1'b0);
    chk("t4_idle_starts", starts_b, 0);
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    chk("t3_busy", busy_b, 1'b1);
    for (int i = 0; i < 4000 && !config_err_b; i++) tick(1);
    chk("t3_err", config_err_b, 1'b1);
    chk("t3_err_index", err_index_b, 8'h00);
    chk("t3_done", config_done_b, 1'b0);
    chk("t3_busy_end", busy_b, 1'b0);
    chk("t3_attempts", starts_b, 3);
    tick(1000);
    chk("t3_no_more", starts_b, 3);

    // T1/T5: auto start after reset release, slave ACKs everything
    reset = 1'b0;
    tick(2);
    chk("t1_autostart_busy", busy, 1'b1);
    wait_done("t1_done");
    chk("t1_busy", busy, 1'b0);
    chk("t1_err", config_err, 1'b0);
    chk("t1_starts", starts, 2);
    chk("t1_stops", stops, 2);
    chk("t1_nacks", nacks, 0);
    chk_bytes("t1", exp_full);
    chk("t5_sda_on_scl_edge", sim_chg, 0);
    chk("t5_period_err", tim_err, 0);
    chk("t5_high_periods", hi_chk, 54);
    chk("t5_low_periods", lo_chk, 54);

    // T2: one NACK on the HI byte of entry 1
    nack_mode = 1;
    clear_mon();
    pulse_start();
    chk("t2_done_cleared", config_done, 1'b0);
    wait_done("t2_done");
    chk("t2_err", config_err, 1'b0);
    chk("t2_starts", starts, 3);
    chk("t2_stops", stops, 3);
    chk("t2_nacks", nacks, 1);
    chk_bytes("t2", exp_nack);
    chk("t2_sda_on_scl_edge", sim_chg, 0);

    // T6: start while busy is ignored
    nack_mode = 0;
    clear_mon();
    pulse_start();
    tick(300);
    chk("t6_busy", busy, 1'b1);
    chk("t6_done_cleared", config_done, 1'b0);
    pulse_start();
    wait_done("t6_done");
    chk("t6_starts", starts, 2);
    chk_bytes("t6", exp_full);

    // T4: asynchronous reset in the middle of the address byte
    clear_mon();
    pulse_start();
    for (int i = 0; i < 600 && !(busy && scl_oe && sda_oe && (rise_idx >= 1)); i++) tick(1);
    chk("t4_pre_scl", scl_oe, 1'b1);
    chk("t4_pre_sda", sda_oe, 1'b1);
    reset = 1'b1;
    #1;
    chk("t4_scl_released", scl_oe, 1'b0);
    chk("t4_sda_released", sda_oe, 1'b0);
    chk("t4_busy", busy, 1'b0);
    tick(3);
    chk("t4_done_cleared", config_done, 1'b0);
    reset = 1'b0;
    wait_done("t4_rerun_done");
    chk("t4_rerun_starts", starts, 2);
    chk_bytes("t4", exp_full);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
